elevator_call_panel: RTL and testbench
======================================

# elevator_call_panel

Request-side partner of the elevator controller: takes the 12 raw hall and car pushbuttons, synchronizes and debounces them, and latches each press as a pending request. It drives the controller's `u`, `d`, `i` request vectors and clears a floor's requests when the controller reports the door open at that floor. It sits between the physical button inputs and the elevator controller; its registered outputs also drive the button lamps.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must differ from the stable level before it is accepted. Legal range is 1..255.
- `clk` in 1: single clock; all state updates on the posedge.
- `reset` in 1: synchronous, active-high.
- `u_btn` in 4: raw up buttons, bit n = floor n+1. Bit 3 does not exist and is ignored.
- `d_btn` in 4: raw down buttons. Bit 0 does not exist and is ignored.
- `i_btn` in 4: raw in-car floor buttons.
- `F` in 3: controller floor code. 000–011 = F1–F4; 100/101/110 = between floors.
- `dir` in 2: controller direction. 0x = stopped, 10 = down, 11 = up.
- `door` in 1: controller door, 1 = open.
- `u` out 4: latched up requests, to controller and lamps. `u[3]` is always 0.
- `d` out 4: latched down requests. `d[0]` is always 0.
- `i` out 4: latched car requests.
- `req_pending` out 1: registered OR of all bits of `u`, `d` and `i`.

## Operation
- **Per button (10 live buttons):**
  - 2-flop synchronizer: `s1 <= raw`, `s2 <= s1`.
  - Debouncer holds a stable level `st` and a counter `cnt`.
  - If `s2 == st`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `st <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Counter width is 8 bits.
- **Press event:** occurs on the edge where `st` goes 0→1. A 1→0 transition of `st` (release) has no effect on requests.
- **Set:** a press event sets the matching request bit on that same edge.
- **Service condition:** `svc = door==1 && dir[1]==0 && F[2]==0`. The served floor is `f = F[1:0]`.
- **Clear:** when `svc` holds, clear `u[f]`, `d[f]` and `i[f]` on that edge. Other floors are untouched.
- **Simultaneous set and clear, same floor:** clear wins. A press at a floor whose door is already open is dropped.
- **Simultaneous set and clear, different floors:** both take effect.
- **Held button:** a continuously held button produces exactly one press event. A request cleared while its button is still held stays clear until the button is released (debounced) and pressed again.
- **Between floors:** `F` in 100–110 with `door==1` is illegal; no clear occurs.
- **Non-existent buttons:** `u_btn[3]` and `d_btn[0]` have no synchronizer or debouncer. Their outputs are held constant 0.
- **Request states:** each request bit is a two-state machine, IDLE(0) → PENDING(1) on a press event, PENDING → IDLE on `svc` for its floor. No other transitions.
- **Reset:** all synchronizer flops, `st`, `cnt`, `u`, `d`, `i` and `req_pending` go to 0 on the next edge with `reset==1`.
  - Reset mid-debounce discards the partial count.
  - A button held through reset is re-detected as a new press after reset deasserts.

## Timing
- **Press latency:** raw first sampled high at edge k (stable and glitch-free) gives:
  - `s2=1` after edge k+1;
  - request bit 1 after edge k+1+`DEBOUNCE_CYCLES`. With the default, that is 5 edges.
- **`req_pending`** is registered one edge after the request vectors.
- **Glitch rejection:** a raw pulse whose synchronized width is shorter than `DEBOUNCE_CYCLES` cycles produces no request.
- **Clear latency:** `svc` sampled at edge c clears the requests at edge c. The output is low after that edge and `req_pending` follows one edge later.
- **Controller interface:**
  - The controller samples on the negedge. Outputs change only on posedge, so they are stable half a cycle before the controller samples them.
  - `F`, `dir` and `door` are controller negedge registers and are sampled here on posedge without further synchronization.
- **After reset:** all outputs are 0 from the first edge with reset asserted until the first press completes.

## Test plan
- **Basic press:** `DEBOUNCE_CYCLES=4`, reset, then hold `i_btn=0100` from edge k. `i=0000` through edge k+4; `i=0100` after edge k+5; `req_pending=1` after edge k+6.
- **Glitch:** `u_btn[1]` high for 3 cycles, then low. `u` stays 0000 and `req_pending` stays 0 for 20 cycles.
- **Service clear:** latch `u[1]`, `i[1]` and `d[2]`. Drive `F=001`, `dir=00`, `door=1` for one cycle. Next edge gives `u=0000`, `i=0000`, `d=0100`.
- **Set/clear collision:** `F=010`, `door=1`, `dir=00` held while the `d_btn[2]` debounce completes. `d[2]` stays 0. After release and re-press with `door=0`, `d[2]=1`.
- **Non-existent buttons:** hold `u_btn=1000` and `d_btn=0001` for 20 cycles. `u` and `d` stay 0000.
- **Reset mid-operation:** latch `u=0011` and `i=1000`, keep `i_btn[3]` held, pulse reset for 1 edge r.
  - After edge r: all outputs 0.
  - `i[3]` re-latches after edge r+6.

Source files
------------

// File: rtl/elevator_call_panel.sv
// Elevator call panel: synchronizes and debounces the hall/car buttons and
// latches presses as pending requests until the door opens at that floor.

module ecp_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1, s2, st;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Fires on the same edge that st is about to rise, so the request sets with it.
  assign press = s2 & ~st & (cnt == LIM);
endmodule

module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] u_btn,
  input  logic [3:0] d_btn,
  input  logic [3:0] i_btn,
  input  logic [2:0] F,
  input  logic [1:0] dir,
  input  logic       door,
  output logic [3:0] u,
  output logic [3:0] d,
  output logic [3:0] i,
  output logic       req_pending
);
  // Button index: [3:0] up, [7:4] down, [11:8] car. No up at F4, no down at F1.
  localparam logic [11:0] LIVE = 12'b1111_1110_0111;

  logic [11:0] raw, press, req_q, req_d;
  logic [3:0]  clr;
  logic        svc;
  logic        unused_in;

  assign raw       = {i_btn, d_btn, u_btn};
  assign unused_in = ^{raw[3], raw[4], dir[0]};

  for (genvar b = 0; b < 12; b++) begin : g_btn
    if (LIVE[b]) begin : g_live
      ecp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw[b]),
        .press (press[b])
      );
    end else begin : g_dead
      assign press[b] = 1'b0;
    end
  end

  // Between-floor codes (F[2]=1) never clear, even with the door open.
  assign svc = door & ~dir[1] & ~F[2];
  assign clr = svc ? (4'b0001 << F[1:0]) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= '0;
      req_pending <= 1'b0;
    end else begin
      req_q       <= req_d;
      req_pending <= |req_q;
    end
  end

  // Each bit: IDLE -> PENDING on press, PENDING -> IDLE on service; clear wins.
  always_comb begin
    req_d = (req_q | press) & ~{clr, clr, clr} & LIVE;
  end

  always_comb begin
    u = req_q[3:0];
    d = req_q[7:4];
    i = req_q[11:8];
  end
endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with DEBOUNCE_CYCLES=4.
module tb_elevator_call_panel;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] u_btn, d_btn, i_btn;
  logic [2:0] F;
  logic [1:0] dir;
  logic       door;
  logic [3:0] u, d, i;
  logic       req_pending;

  int checks = 0;
  int errors = 0;

  elevator_call_panel #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .u_btn       (u_btn),
    .d_btn       (d_btn),
    .i_btn       (i_btn),
    .F           (F),
    .dir         (dir),
    .door        (door),
    .u           (u),
    .d           (d),
    .i           (i),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past n posedges; inputs driven afterwards are first sampled on the next edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; u_btn = '0; d_btn = '0; i_btn = '0;
    F = 3'b000; dir = 2'b00; door = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_u", u, 0); chk("rst_d", d, 0); chk("rst_i", i, 0); chk("rst_pend", req_pending, 0);

    // Glitch: 3 sampled cycles high is one short of the debounce window.
    u_btn = 4'b0010; tick(3); u_btn = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("glitch_u", u, 0);
      chk("glitch_pend", req_pending, 0);
    end

    // Basic press: first sampled at edge k, latched after k+5.
    i_btn = 4'b0100;
    tick(5); chk("press_i_k4", i, 4'b0000);
    tick(1); chk("press_i_k5", i, 4'b0100); chk("press_pend_k5", req_pending, 0);
    tick(1); chk("press_pend_k6", req_pending, 1);
    i_btn = 4'b0000; tick(8);

    // Service clear at floor 2 only; i[2] from before is another floor.
    u_btn = 4'b0010; i_btn = 4'b0010; d_btn = 4'b0100;
    tick(6);
    u_btn = '0; i_btn = '0; d_btn = '0;
    chk("svc_pre_u", u, 4'b0010); chk("svc_pre_i", i, 4'b0110); chk("svc_pre_d", d, 4'b0100);
    F = 3'b001; door = 1'b1; tick(1); door = 1'b0;
    chk("svc_u", u, 4'b0000); chk("svc_i", i, 4'b0100); chk("svc_d", d, 4'b0100);
    chk("svc_pend", req_pending, 1);
    F = 3'b010; door = 1'b1; tick(1); door = 1'b0;
    chk("svc2_i", i, 0); chk("svc2_d", d, 0);
    tick(1); chk("svc2_pend", req_pending, 0);
    tick(6);

    // No clear between floors or while moving down.
    i_btn = 4'b0001; tick(6); i_btn = '0;
    chk("bf_set_i", i, 4'b0001);
    F = 3'b100; door = 1'b1; tick(1); chk("bf_noclr", i, 4'b0001);
    F = 3'b000; dir = 2'b10; tick(1); chk("dn_noclr", i, 4'b0001);
    dir = 2'b00; tick(1); chk("stop_clr", i, 4'b0000);
    door = 1'b0; tick(6);

    // Set/clear collision: press completes while door open at that floor.
    F = 3'b010; door = 1'b1; d_btn = 4'b0100;
    tick(8); chk("coll_d", d, 0);
    d_btn = '0; door = 1'b0; tick(8);
    d_btn = 4'b0100; tick(6); chk("repress_d", d, 4'b0100);

    // Held button cleared stays clear.
    door = 1'b1; tick(1); door = 1'b0; chk("held_clr", d, 0);
    tick(10); chk("held_stay", d, 0);
    d_btn = '0; tick(8);

    // Buttons that do not exist.
    u_btn = 4'b1000; d_btn = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("ghost_u", u, 0);
      chk("ghost_d", d, 0);
    end
    u_btn = '0; d_btn = '0; tick(2);

    // Reset mid-operation with i_btn[3] held through it.
    F = 3'b101;
    u_btn = 4'b0011; i_btn = 4'b1000; tick(6); u_btn = '0;
    chk("pre_rst_u", u, 4'b0011); chk("pre_rst_i", i, 4'b1000);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("r_u", u, 0); chk("r_d", d, 0); chk("r_i", i, 0); chk("r_pend", req_pending, 0);
    tick(5); chk("r5_i", i, 0);
    tick(1); chk("r6_i", i, 4'b1000);
    tick(1); chk("r7_pend", req_pending, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
